// File: rtl/riscv_bus_pkg.sv
// Shared types and constants for the riscv_data_bus interconnect.
package riscv_bus_pkg;

  // Bus FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } bus_state_t;

  // Cause codes reported on err_cause_o when error capture is built in
  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_UNMAPPED = 2'd1,
    ERR_TIMEOUT  = 2'd2
  } err_cause_t;

  // Read data returned on any error completion
  localparam logic [31:0] BUS_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/riscv_bus_timeout.sv
// Wait-state watchdog for the data bus: counts BUSY cycles and flags the
// last permitted one. The counter saturates instead of wrapping.
module riscv_bus_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] SAT_CNT  = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] r_cnt;

  // Count enabled cycles from zero, holding at the saturation value
  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      r_cnt <= '0;
    end else if (enable && (r_cnt != SAT_CNT)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // High during the final wait cycle the slave is allowed
  assign expired = enable && (r_cnt == LAST_CNT);

endmodule

// File: rtl/riscv_data_bus.sv
// Data-side interconnect: routes one LSU request to one of N_SLAVES
// devices selected by address bits [SEL_MSB:SEL_LSB]. Unmapped regions
// and slaves that stall past TIMEOUT_CYCLES finish as bus errors.
// Optional build macro RISCV_BUS_ERR_CAPTURE_EN adds err_addr_o and
// err_cause_o, which record the address and cause of the latest error.
module riscv_data_bus
  import riscv_bus_pkg::*;
#(
  parameter int          N_SLAVES       = 4,
  parameter int          SEL_MSB        = 31,
  parameter int          SEL_LSB        = 24,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = BUS_ERR_RDATA
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           wd_i,
  output logic [31:0]           rd_o,
  output logic                  ready_o,
  output logic                  err_o,
`ifdef RISCV_BUS_ERR_CAPTURE_EN
  output logic [31:0]           err_addr_o,
  output logic [1:0]            err_cause_o,
`endif
  output logic [N_SLAVES-1:0]   slv_req_o,
  output logic                  slv_we_o,
  output logic [3:0]            slv_be_o,
  output logic [31:0]           slv_addr_o,
  output logic [31:0]           slv_wd_o,
  input  logic [32*N_SLAVES-1:0] slv_rd_i,
  input  logic [N_SLAVES-1:0]   slv_ready_i
);

  localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int RW    = SEL_MSB - SEL_LSB + 1;

  bus_state_t       r_state;
  logic [SEL_W-1:0] r_sel;

  logic [31:0] w_region;
  logic        w_mapped;
  logic        w_sel_ready;
  logic [31:0] w_sel_rd;
  logic        w_busy;
  logic        w_err_st;
  logic        w_expired;
  logic        w_done;

  // Zero-extend the region field so it can be compared against N_SLAVES
  always_comb begin
    w_region         = '0;
    w_region[RW-1:0] = addr_i[SEL_MSB:SEL_LSB];
  end

  assign w_mapped = (w_region < 32'(N_SLAVES));

  // Outputs are suppressed while reset is held, whatever the current state
  assign w_busy   = (r_state == BUSY) && !rst_i;
  assign w_err_st = (r_state == ERR)  && !rst_i;

  // Pick ready and read data of the latched slave; other slaves are ignored
  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_rd    = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (r_sel == SEL_W'(k)) begin
        w_sel_ready = slv_ready_i[k];
        w_sel_rd    = slv_rd_i[32*k +: 32];
      end
    end
  end

  // One-hot request to the latched slave, only while waiting on it
  generate
    for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_req
      assign slv_req_o[gi] = w_busy && (r_sel == SEL_W'(gi));
    end
  endgenerate

  riscv_bus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear  (r_state != BUSY),
    .enable (r_state == BUSY),
    .expired(w_expired)
  );

  // Bus FSM: accept in IDLE, wait for the slave in BUSY, one-cycle ERR
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_sel   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_i) begin
            if (w_mapped) begin
              r_sel   <= w_region[SEL_W-1:0];
              r_state <= BUSY;
            end else begin
              r_state <= ERR;
            end
          end
        end
        BUSY: begin
          // A ready on the last allowed cycle still completes normally
          if (w_sel_ready) begin
            r_state <= IDLE;
          end else if (w_expired) begin
            r_state <= ERR;
          end
        end
        ERR:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_done  = w_busy && w_sel_ready;
  assign ready_o = w_done || w_err_st;
  assign err_o   = w_err_st;
  assign rd_o    = w_err_st ? ERR_RDATA : (w_done ? w_sel_rd : 32'h0);

  // Master fields are broadcast unchanged; only slv_req_o selects a slave
  assign slv_we_o   = we_i;
  assign slv_be_o   = be_i;
  assign slv_addr_o = addr_i;
  assign slv_wd_o   = wd_i;

`ifdef RISCV_BUS_ERR_CAPTURE_EN
  logic [31:0] r_err_addr;
  err_cause_t  r_err_cause;

  // Record address and cause on every transition into ERR
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err_addr  <= '0;
      r_err_cause <= ERR_NONE;
    end else if ((r_state == IDLE) && req_i && !w_mapped) begin
      r_err_addr  <= addr_i;
      r_err_cause <= ERR_UNMAPPED;
    end else if ((r_state == BUSY) && !w_sel_ready && w_expired) begin
      r_err_addr  <= addr_i;
      r_err_cause <= ERR_TIMEOUT;
    end
  end

  assign err_addr_o  = r_err_addr;
  assign err_cause_o = r_err_cause;
`endif

endmodule
